// File: rtl/sample_div_pkg.sv
// Shared constants, state encoding and sign helper for the signed-by-unsigned
// sequential divider.
package sample_div_pkg;

    localparam int DIN0_W = 11;
    localparam int DIN1_W = 6;
    localparam int PREM_W = DIN1_W + 1;
    localparam int ITER_W = 4;

    localparam logic [ITER_W-1:0] LAST_ITER = 4'd10;

    localparam logic [DIN0_W-1:0] DIV0_POS = 11'h3FF;
    localparam logic [DIN0_W-1:0] DIV0_NEG = 11'h400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Two's-complement negate when neg is set; -1024 maps onto itself.
    function automatic logic [DIN0_W-1:0] neg_if(input logic neg, input logic [DIN0_W-1:0] v);
        logic [DIN0_W-1:0] res;
        if (neg) begin
            res = ~v + 11'd1;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_sdiv_11s6u_seq_if.sv
// Start/done request bus of the sequential divider.
interface sample_sdiv_11s6u_seq_if;
    import sample_div_pkg::*;

    logic              start;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              busy;
    logic              done;
    logic [DIN0_W-1:0] dout;
    logic [DIN0_W-1:0] rem;

    modport master (output start, din0, din1, input busy, done, dout, rem);
    modport slave  (input start, din0, din1, output busy, done, dout, rem);

endinterface

// File: rtl/sample_sdiv_11s6u_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract,
// keep the difference only when it does not borrow.
module sample_sdiv_11s6u_step
    import sample_div_pkg::*;
(
    input  logic [DIN1_W-1:0] prem,
    input  logic              bit_in,
    input  logic [DIN1_W-1:0] divisor,
    output logic [PREM_W-1:0] prem_next,
    output logic              q_bit
);

    logic [PREM_W-1:0] shifted_s;
    logic [PREM_W:0]   diff_s;

    // The incoming remainder is always below the divisor, so six bits carry it.
    always_comb begin
        shifted_s = {prem, bit_in};
        diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
        if (diff_s[PREM_W]) begin
            prem_next = shifted_s;
            q_bit     = 1'b0;
        end else begin
            prem_next = diff_s[PREM_W-1:0];
            q_bit     = 1'b1;
        end
    end

endmodule

// File: rtl/sample_sdiv_11s6u_seq.sv
// Sequential 11-bit signed / 6-bit unsigned divider with C truncation,
// one restoring iteration per enabled cycle behind a start/done handshake.
module sample_sdiv_11s6u_seq
    import sample_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DIN0_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    sample_sdiv_11s6u_seq_if.slave bus
);

    // ID is informational only; a negative value is simply not meaningful.
    if (ID < 0) begin : g_id_invalid
    end

    localparam int PAD_W = dout_WIDTH - PREM_W;

    div_state_e              state_r, state_s;
    logic [din0_WIDTH-1:0]   mag_r, quot_r, dividend_r;
    logic [din1_WIDTH-1:0]   divisor_r;
    logic [PREM_W-1:0]       prem_r, step_prem_s;
    logic [ITER_W-1:0]       iter_r;
    logic                    neg_r, step_q_s, accept_s;
    logic                    busy_r, done_r;
    logic [dout_WIDTH-1:0]   dout_r, rem_r, fix_q_s, fix_r_s;

    assign accept_s = bus.start & ~busy_r;

    sample_sdiv_11s6u_step u_step (
        .prem      (prem_r[DIN1_W-1:0]),
        .bit_in    (mag_r[din0_WIDTH-1]),
        .divisor   (divisor_r),
        .prem_next (step_prem_s),
        .q_bit     (step_q_s)
    );

    // Next-state logic of the control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (iter_r == LAST_ITER) state_s = ST_FIX;
                else                     state_s = ST_RUN;
            end
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sign correction; a zero divisor saturates and echoes the dividend as remainder.
    always_comb begin
        fix_q_s = {dout_WIDTH{1'b0}};
        fix_r_s = {dout_WIDTH{1'b0}};
        if (divisor_r == {din1_WIDTH{1'b0}}) begin
            fix_q_s = neg_r ? DIV0_NEG : DIV0_POS;
            fix_r_s = dividend_r;
        end else begin
            fix_q_s = neg_if(neg_r, quot_r);
            fix_r_s = neg_if(neg_r, {{PAD_W{1'b0}}, prem_r});
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)   state_r <= ST_IDLE;
        else if (ce) state_r <= state_s;
        else         state_r <= state_r;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_r      <= {din0_WIDTH{1'b0}};
            quot_r     <= {din0_WIDTH{1'b0}};
            dividend_r <= {din0_WIDTH{1'b0}};
            divisor_r  <= {din1_WIDTH{1'b0}};
            prem_r     <= {PREM_W{1'b0}};
            iter_r     <= {ITER_W{1'b0}};
            neg_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dout_r     <= {dout_WIDTH{1'b0}};
            rem_r      <= {dout_WIDTH{1'b0}};
        end else if (ce) begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mag_r      <= neg_if(bus.din0[din0_WIDTH-1], bus.din0);
                        dividend_r <= bus.din0;
                        divisor_r  <= bus.din1;
                        neg_r      <= bus.din0[din0_WIDTH-1];
                        quot_r     <= {din0_WIDTH{1'b0}};
                        prem_r     <= {PREM_W{1'b0}};
                        iter_r     <= {ITER_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    mag_r  <= {mag_r[din0_WIDTH-2:0], 1'b0};
                    quot_r <= {quot_r[din0_WIDTH-2:0], step_q_s};
                    prem_r <= step_prem_s;
                    iter_r <= (iter_r == LAST_ITER) ? {ITER_W{1'b0}} : iter_r + 4'd1;
                end
                ST_FIX: begin
                    dout_r <= fix_q_s;
                    rem_r  <= fix_r_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dout = dout_r;
    assign bus.rem  = rem_r;

endmodule

// File: tb/tb_sample_sdiv_11s6u_seq.sv
// Self-checking bench: directed and randomized divisions against a
// behavioural reference built on integer / and %.
module tb_sample_sdiv_11s6u_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;

    sample_sdiv_11s6u_seq_if bus ();

    sample_sdiv_11s6u_seq #(
        .ID(1), .din0_WIDTH(11), .din1_WIDTH(6), .dout_WIDTH(11)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state (what the outputs must be after each edge).
    int m_busy = 0, m_done = 0, m_q = 0, m_r = 0, m_cnt = 0;
    int p_q = 0, p_r = 0;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (a < 0) ? -1024 : 1023;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Behavioural timing model: result appears 12 enabled edges after accept.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_cnt = 0;
        end else if (ce) begin
            if (m_done != 0) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_busy != 0) begin
                m_cnt++;
                if (m_cnt == 12) begin
                    m_done = 1;
                    m_q = p_q;
                    m_r = p_r;
                end
            end else if (bus.start) begin
                m_busy = 1;
                m_cnt = 0;
                ref_div(int'($signed(bus.din0)), int'(bus.din1), p_q, p_r);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("dout", $signed(bus.dout), m_q);
            check("rem", $signed(bus.rem), m_r);
        end
    end

    task automatic run_div(input int a, input int b, input bit rand_ce, input int stall_at,
                           input int stall_len, input int inj_at,
                           output int q, output int r, output int lat);
        bus.start = 1'b1;
        bus.din0 = 11'(a);
        bus.din1 = 6'(b);
        ce = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (lat == inj_at) begin
                bus.start = 1'b1;
                bus.din0 = 11'sd50;
                bus.din1 = 6'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (rand_ce) ce = ($urandom_range(0, 3) != 0);
            else         ce = !(lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        ce = 1'b1;
        bus.start = 1'b0;
        check("done_seen", bus.done, 1);
        q = $signed(bus.dout);
        r = $signed(bus.rem);
    endtask

    task automatic after_done();
        @(posedge clk); #1;
        check("busy_after", bus.busy, 0);
        check("done_after", bus.done, 0);
    endtask

    initial begin
        int q, r, lat, a, b, eq, er, n_done;
        bus.start = 1'b0;
        bus.din0 = 11'd0;
        bus.din1 = 6'd0;

        // Pin the reference model with hand-computed values.
        ref_div(100, 7, q, r);    check("model_100_7_q", q, 14);   check("model_100_7_r", r, 2);
        ref_div(-100, 7, q, r);   check("model_m100_7_q", q, -14); check("model_m100_7_r", r, -2);
        ref_div(-5, 0, q, r);     check("model_m5_0_q", q, -1024); check("model_m5_0_r", r, -5);

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_dout", $signed(bus.dout), 0);

        run_div(100, 7, 0, 0, 0, -1, q, r, lat);
        check("100_7_q", q, 14); check("100_7_r", r, 2); check("100_7_lat", lat, 13);
        after_done();

        run_div(-100, 7, 0, 0, 0, -1, q, r, lat);
        check("m100_7_q", q, -14); check("m100_7_r", r, -2);
        after_done();
        run_div(-1024, 1, 0, 0, 0, -1, q, r, lat);
        check("m1024_1_q", q, -1024); check("m1024_1_r", r, 0);
        after_done();
        run_div(1023, 63, 0, 0, 0, -1, q, r, lat);
        check("1023_63_q", q, 16); check("1023_63_r", r, 15);
        after_done();

        run_div(5, 0, 0, 0, 0, -1, q, r, lat);
        check("5_0_q", q, 1023); check("5_0_r", r, 5); check("5_0_lat", lat, 13);
        after_done();
        run_div(-5, 0, 0, 0, 0, -1, q, r, lat);
        check("m5_0_q", q, -1024); check("m5_0_r", r, -5); check("m5_0_lat", lat, 13);
        after_done();

        // Three ce-low cycles mid-RUN, then done held while ce stays low.
        run_div(100, 7, 0, 5, 3, -1, q, r, lat);
        check("stall_q", q, 14); check("stall_r", r, 2); check("stall_lat", lat, 16);
        ce = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("done_held", bus.done, 1);
        end
        ce = 1'b1;
        after_done();

        // Start while busy must be ignored.
        run_div(100, 7, 0, 0, 0, 4, q, r, lat);
        check("ign_q", q, 14); check("ign_r", r, 2); check("ign_lat", lat, 13);
        after_done();
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("ign_no_second_done", n_done, 0);

        // Reset in the middle of RUN.
        bus.start = 1'b1; bus.din0 = 11'sd100; bus.din1 = 6'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_busy", bus.busy, 0); check("rst_done", bus.done, 0);
        check("rst_dout", $signed(bus.dout), 0); check("rst_rem", $signed(bus.rem), 0);
        run_div(9, 2, 0, 0, 0, -1, q, r, lat);
        check("9_2_q", q, 4); check("9_2_r", r, 1);
        after_done();

        // Randomized operands with random ce stalls.
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 2047)) - 1024;
            b = int'($urandom_range(0, 63));
            run_div(a, b, 1, 0, 0, -1, q, r, lat);
            ref_div(a, b, eq, er);
            check("rand_q", q, eq);
            check("rand_r", r, er);
            after_done();
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
